// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, write/read FSM state
// encodings and a byte-strobe expansion helper.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    // Expand a 4-bit byte strobe into a 32-bit bit mask.
    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// Combinational AXI4-Lite address decode: word index plus out-of-range flag.
module axi4_lite_addr_decode #(
    parameter int IDX_W = 3
) (
    input  logic [31:0]      addr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             err_o
);

    assign idx_o = addr_i[IDX_W+1:2];
    assign err_o = |addr_i[31:IDX_W+2];

    // Byte offset within the word does not affect the decode.
    logic unused_byte_offset;
    assign unused_byte_offset = ^addr_i[1:0];

endmodule

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave register file. Register 0 is a read-only ID register;
// the remaining registers are byte-strobe writable. AW and W may arrive in
// either order; read and write paths run independently.
module axi4_lite_slave_regfile
    import axi4_lite_pkg::*;
#(
    parameter int          NUM_REGS = 8,
    parameter logic [31:0] ID_VALUE = 32'hA4100001
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [31:0]              awaddr_in,
    input  logic [2:0]               awprot_in,
    input  logic                     awvalid_in,
    output logic                     awready_out,
    input  logic [31:0]              wdata_in,
    input  logic [3:0]               wstrb_in,
    input  logic                     wvalid_in,
    output logic                     wready_out,
    output logic [1:0]               bresp_out,
    output logic                     bvalid_out,
    input  logic                     bready_in,
    input  logic [31:0]              araddr_in,
    input  logic [2:0]               arprot_in,
    input  logic                     arvalid_in,
    output logic                     arready_out,
    output logic [31:0]              rdata_out,
    output logic [1:0]               rresp_out,
    output logic                     rvalid_out,
    input  logic                     rready_in,
    output logic [32*NUM_REGS-1:0]   regs_out
);

    localparam int IDX_W = $clog2(NUM_REGS);

    // ---------------------------------------------------------------
    // Address decode, one per address channel
    // ---------------------------------------------------------------
    logic [IDX_W-1:0] aw_idx;
    logic             aw_err;
    logic [IDX_W-1:0] ar_idx;
    logic             ar_err;

    axi4_lite_addr_decode #(.IDX_W(IDX_W)) u_aw_decode (
        .addr_i (awaddr_in),
        .idx_o  (aw_idx),
        .err_o  (aw_err)
    );

    axi4_lite_addr_decode #(.IDX_W(IDX_W)) u_ar_decode (
        .addr_i (araddr_in),
        .idx_o  (ar_idx),
        .err_o  (ar_err)
    );

    // Protection attributes carry no meaning for this register bank.
    logic unused_prot;
    assign unused_prot = ^{awprot_in, arprot_in};

    // ---------------------------------------------------------------
    // Write path
    // ---------------------------------------------------------------
    wr_state_e        wr_state_q, wr_state_d;
    logic [IDX_W-1:0] aw_idx_q,   aw_idx_d;
    logic             aw_err_q,   aw_err_d;
    logic [31:0]      wdata_q,    wdata_d;
    logic [3:0]       wstrb_q,    wstrb_d;
    logic [1:0]       bresp_q,    bresp_d;

    logic             aw_hs;
    logic             w_hs;
    logic             commit;
    logic [IDX_W-1:0] commit_idx;
    logic             commit_err;
    logic [31:0]      commit_data;
    logic [3:0]       commit_strb;
    logic             commit_reject;
    logic [31:0]      commit_mask;

    // Readies depend on state only, so there is no valid-to-ready path.
    assign awready_out = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_DATA);
    assign wready_out  = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_ADDR);
    assign bvalid_out  = (wr_state_q == W_RESP);
    assign bresp_out   = bresp_q;

    assign aw_hs = awvalid_in && awready_out;
    assign w_hs  = wvalid_in  && wready_out;

    // Whichever half arrived first comes from the holding registers,
    // the half completing the pair comes straight from the bus.
    assign commit_idx    = (wr_state_q == W_HAVE_ADDR) ? aw_idx_q : aw_idx;
    assign commit_err    = (wr_state_q == W_HAVE_ADDR) ? aw_err_q : aw_err;
    assign commit_data   = (wr_state_q == W_HAVE_DATA) ? wdata_q  : wdata_in;
    assign commit_strb   = (wr_state_q == W_HAVE_DATA) ? wstrb_q  : wstrb_in;
    assign commit_reject = commit_err || (commit_idx == '0);
    assign commit_mask   = strb_to_mask(commit_strb);

    // Write FSM next-state, holding-register capture and commit strobe.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through the case statement can leave a latch behind.
        wr_state_d = wr_state_q;
        aw_idx_d   = aw_idx_q;
        aw_err_d   = aw_err_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        commit     = 1'b0;

        unique case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit     = 1'b1;
                    wr_state_d = W_RESP;
                end else if (aw_hs) begin
                    aw_idx_d   = aw_idx;
                    aw_err_d   = aw_err;
                    wr_state_d = W_HAVE_ADDR;
                end else if (w_hs) begin
                    wdata_d    = wdata_in;
                    wstrb_d    = wstrb_in;
                    wr_state_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (w_hs) begin
                    commit     = 1'b1;
                    wr_state_d = W_RESP;
                end
            end
            W_HAVE_DATA: begin
                if (aw_hs) begin
                    commit     = 1'b1;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bready_in) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase

        if (commit) begin
            bresp_d = commit_reject ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Write FSM state and holding registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of evaluation order.
        if (!aresetn) begin
            wr_state_q <= W_IDLE;
            aw_idx_q   <= '0;
            aw_err_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            aw_idx_q   <= aw_idx_d;
            aw_err_q   <= aw_err_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
        end
    end

    // ---------------------------------------------------------------
    // Register bank
    // ---------------------------------------------------------------
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];

    // Byte-lane merge of committed write data into the addressed register.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (commit && !commit_reject && (commit_idx == IDX_W'(i))) begin
                regs_d[i] = (regs_q[i] & ~commit_mask) | (commit_data & commit_mask);
            end
        end
    end

    // Register storage; entry 0 holds the ID and is never written.
    always_ff @(posedge aclk or negedge aresetn) begin
        // NOTE: this array is software-visible state with defined reset
        // values, so it is reset like any other register (not a RAM).
        if (!aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == 0) ? ID_VALUE : 32'h0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[32*g +: 32] = regs_q[g];
    end

    // ---------------------------------------------------------------
    // Read path
    // ---------------------------------------------------------------
    rd_state_e   rd_state_q, rd_state_d;
    logic [31:0] rdata_q,    rdata_d;
    logic [1:0]  rresp_q,    rresp_d;

    assign arready_out = (rd_state_q == R_IDLE);
    assign rvalid_out  = (rd_state_q == R_DATA);
    assign rdata_out   = rdata_q;
    assign rresp_out   = rresp_q;

    // Read FSM next-state; data is captured from the pre-edge register
    // contents, so a same-edge write is not visible to this read.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;

        unique case (rd_state_q)
            R_IDLE: begin
                if (arvalid_in) begin
                    rdata_d    = ar_err ? 32'h0 : regs_q[ar_idx];
                    rresp_d    = ar_err ? RESP_SLVERR : RESP_OKAY;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rready_in) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Read FSM state and registered response.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Scoreboard bench for axi4_lite_slave_regfile: expected responses are
// queued when a transaction is issued and compared when the DUT responds.
module tb_axi4_lite_slave_regfile;

    localparam int          NREG = 8;
    localparam logic [31:0] ID   = 32'hA4100001;
    localparam logic [1:0]  OKAY = 2'b00;
    localparam logic [1:0]  SERR = 2'b10;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [31:0]       awaddr_in;
    logic [2:0]        awprot_in;
    logic              awvalid_in;
    logic              awready_out;
    logic [31:0]       wdata_in;
    logic [3:0]        wstrb_in;
    logic              wvalid_in;
    logic              wready_out;
    logic [1:0]        bresp_out;
    logic              bvalid_out;
    logic              bready_in;
    logic [31:0]       araddr_in;
    logic [2:0]        arprot_in;
    logic              arvalid_in;
    logic              arready_out;
    logic [31:0]       rdata_out;
    logic [1:0]        rresp_out;
    logic              rvalid_out;
    logic              rready_in;
    logic [32*NREG-1:0] regs_out;

    axi4_lite_slave_regfile #(.NUM_REGS(NREG), .ID_VALUE(ID)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .awaddr_in   (awaddr_in),
        .awprot_in   (awprot_in),
        .awvalid_in  (awvalid_in),
        .awready_out (awready_out),
        .wdata_in    (wdata_in),
        .wstrb_in    (wstrb_in),
        .wvalid_in   (wvalid_in),
        .wready_out  (wready_out),
        .bresp_out   (bresp_out),
        .bvalid_out  (bvalid_out),
        .bready_in   (bready_in),
        .araddr_in   (araddr_in),
        .arprot_in   (arprot_in),
        .arvalid_in  (arvalid_in),
        .arready_out (arready_out),
        .rdata_out   (rdata_out),
        .rresp_out   (rresp_out),
        .rvalid_out  (rvalid_out),
        .rready_in   (rready_in),
        .regs_out    (regs_out)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0]  b_q[$];
    logic [33:0] r_q[$];
    logic [31:0] model [NREG];

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) model[i] = (i == 0) ? ID : 32'h0;
    endtask

    function automatic logic [32*NREG-1:0] model_bus();
        logic [32*NREG-1:0] bus;
        for (int i = 0; i < NREG; i++) bus[32*i +: 32] = model[i];
        return bus;
    endfunction

    function automatic logic addr_bad(input logic [31:0] addr);
        return addr[31:5] != 27'h0;
    endfunction

    // Issue AW and W with independent start delays; expected B response
    // and the model update are recorded up front.
    task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly);
        bit aw_done = 0;
        bit w_done  = 0;
        int cyc     = 0;
        logic [31:0] mask;
        if (addr_bad(addr) || addr[4:2] == 3'd0) begin
            b_q.push_back(SERR);
        end else begin
            b_q.push_back(OKAY);
            for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{strb[b]}};
            model[addr[4:2]] = (model[addr[4:2]] & ~mask) | (data & mask);
        end
        awaddr_in = addr;
        wdata_in  = data;
        wstrb_in  = strb;
        awprot_in = 3'($urandom_range(0, 7));
        while (!(aw_done && w_done) && cyc < 50) begin
            awvalid_in = !aw_done && (cyc >= aw_dly);
            wvalid_in  = !w_done  && (cyc >= w_dly);
            @(negedge aclk);
            if (awvalid_in && awready_out) aw_done = 1;
            if (wvalid_in  && wready_out)  w_done  = 1;
            @(posedge aclk); #1;
            cyc++;
        end
        awvalid_in = 1'b0;
        wvalid_in  = 1'b0;
        check("write_handshake_done", {aw_done, w_done}, 2'b11);
        check("b_latency", bvalid_out, 1'b1);
        check("regs_after_write", regs_out, model_bus());
    endtask

    task automatic read_txn(input logic [31:0] addr);
        bit done = 0;
        int cyc  = 0;
        if (addr_bad(addr)) r_q.push_back({SERR, 32'h0});
        else                r_q.push_back({OKAY, model[addr[4:2]]});
        araddr_in = addr;
        arprot_in = 3'($urandom_range(0, 7));
        while (!done && cyc < 50) begin
            arvalid_in = 1'b1;
            @(negedge aclk);
            if (arready_out) done = 1;
            @(posedge aclk); #1;
            cyc++;
        end
        arvalid_in = 1'b0;
        check("read_handshake_done", done, 1'b1);
        check("r_latency", rvalid_out, 1'b1);
    endtask

    // Collect a B response, optionally holding bready low first.
    task automatic get_b(input int hold);
        logic [1:0] exp;
        int cyc = 0;
        exp = b_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            check("b_hold_valid", bvalid_out, 1'b1);
            check("b_hold_resp", bresp_out, exp);
            check("b_hold_awready", awready_out, 1'b0);
            @(posedge aclk); #1;
        end
        bready_in = 1'b1;
        @(negedge aclk);
        while (!bvalid_out && cyc < 20) begin
            @(negedge aclk);
            cyc++;
        end
        check("b_valid", bvalid_out, 1'b1);
        check("bresp", bresp_out, exp);
        @(posedge aclk); #1;
        bready_in = 1'b0;
        check("b_released", bvalid_out, 1'b0);
        check("awready_after_b", awready_out, 1'b1);
    endtask

    task automatic get_r(input int hold);
        logic [33:0] exp;
        int cyc = 0;
        exp = r_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            check("r_hold_valid", rvalid_out, 1'b1);
            check("r_hold_data", {rresp_out, rdata_out}, exp);
            check("r_hold_arready", arready_out, 1'b0);
            @(posedge aclk); #1;
        end
        rready_in = 1'b1;
        @(negedge aclk);
        while (!rvalid_out && cyc < 20) begin
            @(negedge aclk);
            cyc++;
        end
        check("r_valid", rvalid_out, 1'b1);
        check("rresp_rdata", {rresp_out, rdata_out}, exp);
        @(posedge aclk); #1;
        rready_in = 1'b0;
        check("r_released", rvalid_out, 1'b0);
        check("arready_after_r", arready_out, 1'b1);
    endtask

    // AR, AW and W all handshake on the same edge to the same register.
    task automatic concurrent_rw(input logic [31:0] addr, input logic [31:0] data);
        r_q.push_back({OKAY, model[addr[4:2]]});
        b_q.push_back(OKAY);
        model[addr[4:2]] = data;
        araddr_in  = addr;
        awaddr_in  = addr;
        wdata_in   = data;
        wstrb_in   = 4'hF;
        arvalid_in = 1'b1;
        awvalid_in = 1'b1;
        wvalid_in  = 1'b1;
        @(negedge aclk);
        check("conc_readies", {arready_out, awready_out, wready_out}, 3'b111);
        @(posedge aclk); #1;
        arvalid_in = 1'b0;
        awvalid_in = 1'b0;
        wvalid_in  = 1'b0;
        check("conc_valids", {rvalid_out, bvalid_out}, 2'b11);
        check("conc_regs", regs_out, model_bus());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn    = 1'b0;
        awaddr_in  = '0;
        awprot_in  = '0;
        awvalid_in = 1'b0;
        wdata_in   = '0;
        wstrb_in   = '0;
        wvalid_in  = 1'b0;
        bready_in  = 1'b0;
        araddr_in  = '0;
        arprot_in  = '0;
        arvalid_in = 1'b0;
        rready_in  = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_readies", {awready_out, wready_out, arready_out}, 3'b111);
        check("rst_valids", {bvalid_out, rvalid_out}, 2'b00);
        check("rst_resps", {bresp_out, rresp_out}, 4'b0000);
        check("rst_rdata", rdata_out, 32'h0);
        check("rst_regs", regs_out, model_bus());
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // ID register and a cleared register
        read_txn(32'h0);  get_r(0);
        read_txn(32'h4);  get_r(0);

        // AW and W together
        write_txn(32'h8, 32'hDEADBEEF, 4'hF, 0, 0);
        check("reg2_slice", regs_out[95:64], 32'hDEADBEEF);
        get_b(0);
        read_txn(32'h8);  get_r(0);

        // W two cycles ahead of AW, partial strobe
        write_txn(32'hC, 32'hFFFFFFFF, 4'hF, 0, 0);    get_b(0);
        write_txn(32'hC, 32'h11223344, 4'b0101, 2, 0); get_b(0);
        check("reg3_merge", regs_out[127:96], 32'hFF22FF44);
        read_txn(32'hC);  get_r(0);

        // AW ahead of W
        write_txn(32'h10, 32'hCAFEF00D, 4'b1010, 0, 3); get_b(0);
        read_txn(32'h10); get_r(0);

        // Error and boundary cases
        write_txn(32'h0, 32'h12345678, 4'hF, 0, 0);        get_b(0);
        write_txn(32'h20, 32'h12345678, 4'hF, 1, 0);       get_b(0);
        write_txn(32'h80000004, 32'h55555555, 4'hF, 0, 1); get_b(0);
        write_txn(32'h14, 32'h87654321, 4'h0, 0, 0);       get_b(0);
        write_txn(32'h1B, 32'hA5A5A5A5, 4'b1100, 0, 0);    get_b(0);
        read_txn(32'h20); get_r(0);
        read_txn(32'h0);  get_r(0);
        read_txn(32'h1A); get_r(0);

        // Back-pressure on both response channels
        write_txn(32'h1C, 32'h0BADF00D, 4'hF, 0, 0); get_b(5);
        write_txn(32'h4, 32'h00C0FFEE, 4'hF, 0, 0);  get_b(0);
        read_txn(32'h1C); get_r(5);
        read_txn(32'h4);  get_r(0);

        // Same-edge read and write of register 2
        concurrent_rw(32'h8, 32'h600DCAFE);
        get_b(0);
        get_r(0);
        read_txn(32'h8);  get_r(0);

        // Reset while a write holds only its address
        awaddr_in  = 32'h18;
        awvalid_in = 1'b1;
        @(negedge aclk);
        check("mid_aw_ready", awready_out, 1'b1);
        @(posedge aclk); #1;
        awvalid_in = 1'b0;
        check("have_addr_readies", {awready_out, wready_out}, 2'b01);
        #2 aresetn = 1'b0;
        model_reset();
        #1;
        check("mid_rst_bvalid", bvalid_out, 1'b0);
        check("mid_rst_regs", regs_out, model_bus());
        check("mid_rst_readies", {awready_out, wready_out, arready_out}, 3'b111);
        @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("post_rst_no_b", bvalid_out, 1'b0);
        end
        @(posedge aclk); #1;
        read_txn(32'h8);  get_r(0);
        read_txn(32'h0);  get_r(0);

        check("b_queue_empty", 32'(b_q.size()), 32'd0);
        check("r_queue_empty", 32'(r_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_regfile.md
# axi4_lite_slave_regfile

AXI4-Lite slave endpoint with a bank of 32-bit software-visible registers. It sits directly downstream of the 2x2 crossbar in place of a slave adaptor, consuming one slave port (s1 or s2) of the crossbar. It handles independent AW/W arrival, byte-strobe writes, registered read data and SLVERR decode, and exposes register contents to hardware as a flat bus.

## Interface
- NUM_REGS, 8: number of 32-bit registers; index 0 is the read-only ID register; power of two, 2..64.
- ID_VALUE, 32'hA4L1_0001 → 32'hA4100001: reset and constant value of register 0.
- IDX_W, $clog2(NUM_REGS): word-index width (derived localparam).

- aclk  in  1  clock, all logic on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- awaddr_in  in  32  write address; byte address, word index = awaddr_in[IDX_W+1:2].
- awprot_in  in  3  accepted and ignored.
- awvalid_in / awready_out  in / out  1  write address handshake.
- wdata_in  in  32  write data.
- wstrb_in  in  4  byte lane enables.
- wvalid_in / wready_out  in / out  1  write data handshake.
- bresp_out  out  2  00 OKAY, 10 SLVERR.
- bvalid_out / bready_in  out / in  1  write response handshake.
- araddr_in  in  32  read address, same decode as awaddr_in.
- arprot_in  in  3  ignored.
- arvalid_in / arready_out  in / out  1  read address handshake.
- rdata_out  out  32  read data.
- rresp_out  out  2  00 OKAY, 10 SLVERR.
- rvalid_out / rready_in  out / in  1  read data handshake.
- regs_out  out  32*NUM_REGS  register contents; reg i at [32*i+31:32*i].

## Operation
- Decode: error if address bits [31:IDX_W+2] are non-zero (out of range). Bits [1:0] are ignored.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - W_IDLE: awready_out=1, wready_out=1. Both handshake in the same cycle → commit, go to W_RESP. AW only → latch address, go to W_HAVE_ADDR. W only → latch data and strobe, go to W_HAVE_DATA.
  - W_HAVE_ADDR: wready_out=1, awready_out=0. On W handshake → commit, go to W_RESP.
  - W_HAVE_DATA: awready_out=1, wready_out=0. On AW handshake → commit, go to W_RESP.
  - W_RESP: bvalid_out=1, bresp_out held stable. On bready_in → W_IDLE.
- Commit: for each lane b with wstrb[b]=1, reg[idx][8b+7:8b] <= wdata[8b+7:8b]. No update and SLVERR if the address is out of range or idx==0. wstrb=0 with a valid address → no change, OKAY.
- Read FSM states: R_IDLE (arready_out=1) and R_DATA (rvalid_out=1).
  - AR handshake captures rdata_out = reg[idx], or 32'h0 with SLVERR if out of range → R_DATA.
  - On rready_in → R_IDLE.
- Read and write paths are fully independent and may be active concurrently.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): both FSMs go to IDLE; all valids/readies driven per IDLE state; bresp_out=0; rresp_out=0; rdata_out=0; regs 1..N-1 = 0; reg 0 = ID_VALUE.
- Write latency: commit on the edge completing the second of the AW/W handshakes. regs_out updates on that edge. bvalid_out rises the next cycle. Minimum AW→B latency is 1 cycle.
- Read latency: rvalid_out rises 1 cycle after the AR handshake. At most one outstanding read and one outstanding write.
- Same-edge read handshake and write commit to the same register: read returns the pre-write value.
- bvalid_out, rvalid_out, bresp_out, rresp_out and rdata_out stay stable until their ready is sampled high. No combinational path exists from any *valid_in to any *ready_out.
- Reset asserted mid-transaction: the transaction is dropped, no response is issued, and register contents return to reset values.

## Structure
- Shared package axi4_lite_pkg holds RESP_OKAY=2'b00, RESP_SLVERR=2'b10, and the write/read FSM state enums. The crossbar and adaptors reuse these.
- One natural sub-module: axi4_lite_addr_decode, a combinational block taking address in and producing idx and err out. It is instantiated twice, once for AW and once for AR.

## Test plan
- Reset, then read 0x0 → rdata_out=ID_VALUE with OKAY. Read 0x4 → 0x00000000 with OKAY. Every output checked at reset.
- AW and W in the same cycle: addr 0x8, data 0xDEADBEEF, strb 4'hF → bvalid_out next cycle with OKAY. regs_out[95:64]=0xDEADBEEF. Read-back matches.
- W two cycles before AW: data 0x11223344, strb 4'b0101, addr 0xC, preceded by a full write of 0xFFFFFFFF → reg3=0xFF22FF44, OKAY.
- Write to 0x0, or to 0x20 with NUM_REGS=8 → SLVERR and no register change. Read 0x20 → rdata_out=0 with SLVERR.
- bready_in and rready_in held low for 5 cycles → responses held stable. awready_out and arready_out stay 0 until release. Next transaction is accepted the cycle after release.
- Concurrent read and write of reg 2 on the same edge → read returns the old value. A subsequent read returns the new value. Reset asserted during W_HAVE_ADDR → no bvalid_out, and regs are cleared.
